mac_compute_unit: RTL and testbench

Single-tap multiply element for the 3x3 convolution engine. The engine instantiates nine copies, one per kernel tap. Each copy multiplies an unsigned pixel by a signed kernel weight. The product is registered, sign-extended, and fed into the engine's adder tree. The block's fixed latency is part of the engine's result_valid alignment, which is five register stages from window to result.

---
 rtl/mac_compute_unit.sv | 78 +++++++
 tb/tb_mac_compute_unit.sv | 164 ++++++++++++++++
 2 files changed

// File: rtl/mac_compute_unit.sv
`default_nettype none
// ============================================================================
// Module   : mac_compute_unit
// Brief    : Single-tap unsigned-pixel x signed-weight multiplier with a
//            fixed-latency registered output for the 3x3 convolution engine.
// Revision : 1.0 - initial release
// ============================================================================
module mac_compute_unit #(
    parameter int A_WIDTH   = 8,
    parameter int B_WIDTH   = 8,
    parameter int OUT_WIDTH = 18,
    parameter int LATENCY   = 1,
    parameter bit SATURATE  = 1'b0
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [A_WIDTH-1:0]   pixel_a,
    input  logic [B_WIDTH-1:0]   weight_b,
    output logic [OUT_WIDTH-1:0] sum_out
);

    localparam int c_PROD_W = A_WIDTH + B_WIDTH + 1;
    localparam logic [OUT_WIDTH-1:0] c_OUT_MAX = {1'b0, {(OUT_WIDTH-1){1'b1}}};
    localparam logic [OUT_WIDTH-1:0] c_OUT_MIN = {1'b1, {(OUT_WIDTH-1){1'b0}}};

    if ((LATENCY < 1) || (LATENCY > 4) || (OUT_WIDTH < 2)) begin : g_param_check
        $error("mac_compute_unit: LATENCY must be 1..4 and OUT_WIDTH >= 2");
    end

    logic signed [c_PROD_W-1:0] w_a_ext;
    logic signed [c_PROD_W-1:0] w_b_ext;
    logic signed [c_PROD_W-1:0] w_prod;
    logic        [OUT_WIDTH-1:0] w_result;

    // Pixel is always non-negative, so it gets a zero above its MSB.
    assign w_a_ext = {{(B_WIDTH+1){1'b0}}, pixel_a};
    assign w_b_ext = {{(A_WIDTH+1){weight_b[B_WIDTH-1]}}, weight_b};
    assign w_prod  = w_a_ext * w_b_ext;

    if (OUT_WIDTH > c_PROD_W) begin : g_widen
        assign w_result = {{(OUT_WIDTH-c_PROD_W){w_prod[c_PROD_W-1]}}, w_prod};
    end else if (OUT_WIDTH == c_PROD_W) begin : g_exact
        assign w_result = w_prod;
    end else if (SATURATE) begin : g_saturate
        logic [c_PROD_W-OUT_WIDTH:0] w_top;
        assign w_top = w_prod[c_PROD_W-1:OUT_WIDTH-1];
        // In range only when every discarded bit matches the kept sign bit.
        always_comb begin
            w_result = w_prod[OUT_WIDTH-1:0];
            if (!((&w_top) || !(|w_top))) begin
                w_result = w_prod[c_PROD_W-1] ? c_OUT_MIN : c_OUT_MAX;
            end
        end
    end else begin : g_truncate
        logic w_unused_hi;
        assign w_unused_hi = ^w_prod[c_PROD_W-1:OUT_WIDTH];
        assign w_result    = w_prod[OUT_WIDTH-1:0];
    end

    logic [OUT_WIDTH-1:0] r_pipe [LATENCY];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < LATENCY; i++) begin
                r_pipe[i] <= '0;
            end
        end else begin
            r_pipe[0] <= w_result;
            for (int i = 1; i < LATENCY; i++) begin
                r_pipe[i] <= r_pipe[i-1];
            end
        end
    end

    assign sum_out = r_pipe[LATENCY-1];

endmodule
`default_nettype wire

// File: tb/tb_mac_compute_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_mac_compute_unit
// Brief    : Scoreboard bench for mac_compute_unit in four configurations.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mac_compute_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [7:0]  pixel_a = 8'd0;
    logic [7:0]  weight_b = 8'd0;
    logic [17:0] sum_l1;
    logic [17:0] sum_l3;
    logic [11:0] sum_sat;
    logic [11:0] sum_trn;

    int n_chk = 0;
    int n_err = 0;
    int cyc = 0;
    int cur_prod = 0;

    typedef struct {int due; int v18; int vsat; int vtrn;} ent_a_t;
    typedef struct {int due; int v18;} ent_b_t;
    ent_a_t q_a[$];
    ent_b_t q_b[$];

    always #5 clk = ~clk;

    mac_compute_unit #(.LATENCY(1)) u_l1 (
        .clk(clk), .rst(rst), .pixel_a(pixel_a), .weight_b(weight_b), .sum_out(sum_l1));
    mac_compute_unit #(.LATENCY(3)) u_l3 (
        .clk(clk), .rst(rst), .pixel_a(pixel_a), .weight_b(weight_b), .sum_out(sum_l3));
    mac_compute_unit #(.OUT_WIDTH(12), .SATURATE(1'b1)) u_sat (
        .clk(clk), .rst(rst), .pixel_a(pixel_a), .weight_b(weight_b), .sum_out(sum_sat));
    mac_compute_unit #(.OUT_WIDTH(12), .SATURATE(1'b0)) u_trn (
        .clk(clk), .rst(rst), .pixel_a(pixel_a), .weight_b(weight_b), .sum_out(sum_trn));

    function automatic int sat12(input int p);
        if (p > 2047)  return 2047;
        if (p < -2048) return -2048;
        return p;
    endfunction

    function automatic int trn12(input int p);
        int v;
        v = p & 32'h0000_0FFF;
        if (v >= 2048) v = v - 4096;
        return v;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s @cyc %0d: got %0d expected %0d", name, cyc, act, exp);
        end
    endtask

    // Scoreboard push: every edge with rst low samples the operands.
    always @(posedge clk) begin
        cyc++;
        if (!rst) begin
            q_a.push_back(ent_a_t'{cyc, cur_prod, sat12(cur_prod), trn12(cur_prod)});
            q_b.push_back(ent_b_t'{cyc + 2, cur_prod});
        end
    end

    // Monitor: nothing due means the output must read 0.
    always @(negedge clk) begin
        ent_a_t ea;
        ent_b_t eb;
        if (q_a.size() > 0 && q_a[0].due <= cyc) begin
            ea = q_a.pop_front();
            chk("l1", int'($signed(sum_l1)), ea.v18);
            chk("sat12", int'($signed(sum_sat)), ea.vsat);
            chk("trn12", int'($signed(sum_trn)), ea.vtrn);
        end else begin
            chk("l1_idle", int'($signed(sum_l1)), 0);
            chk("sat12_idle", int'($signed(sum_sat)), 0);
            chk("trn12_idle", int'($signed(sum_trn)), 0);
        end
        if (q_b.size() > 0 && q_b[0].due <= cyc) begin
            eb = q_b.pop_front();
            chk("l3", int'($signed(sum_l3)), eb.v18);
        end else begin
            chk("l3_idle", int'($signed(sum_l3)), 0);
        end
    end

    task automatic drive(input int p, input int w, input int e);
        @(negedge clk);
        #2;
        pixel_a  = 8'(p);
        weight_b = 8'(w);
        cur_prod = e;
    endtask

    // Asserted between edges; the one-cycle pulse spans exactly one posedge.
    task automatic do_reset();
        @(negedge clk);
        #2;
        rst = 1'b1;
        q_a.delete();
        q_b.delete();
        #1;
        chk("async_l1", int'($signed(sum_l1)), 0);
        chk("async_l3", int'($signed(sum_l3)), 0);
        chk("async_sat", int'($signed(sum_sat)), 0);
        chk("async_trn", int'($signed(sum_trn)), 0);
        @(negedge clk);
        #2;
        rst = 1'b0;
    endtask

    int dir_p [12] = '{255,    255, 0,    1,  100, 200, 128, 255,  37, 37,  200, 129};
    int dir_w [12] = '{-128,   127, -128, -1, -2,  2,   1,   -1,   2,  -2,  0,   -128};
    int dir_e [12] = '{-32640, 32385, 0,  -1, -200, 400, 128, -255, 74, -74, 0,  -16512};

    initial begin
        #1;
        rst = 1'b1;
        #1;
        chk("reset_l1", int'($signed(sum_l1)), 0);
        chk("reset_l3", int'($signed(sum_l3)), 0);
        chk("reset_sat", int'($signed(sum_sat)), 0);
        chk("reset_trn", int'($signed(sum_trn)), 0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        #2;
        rst = 1'b0;

        for (int i = 0; i < 12; i++) begin
            drive(dir_p[i], dir_w[i], dir_e[i]);
        end

        do_reset();

        for (int i = 0; i < 64; i++) begin
            logic [7:0] pv;
            logic [7:0] wv;
            if (i == 30) do_reset();
            pv = 8'($urandom_range(0, 255));
            wv = 8'($urandom_range(0, 255));
            drive(int'(pv), int'($signed(wv)), int'(pv) * int'($signed(wv)));
        end

        for (int i = 0; i < 4; i++) begin
            drive(0, 0, 0);
        end
        repeat (2) @(negedge clk);
        #1;
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
